// File: rtl/usbpd_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module   : usbpd_rx_decoder
// Brief    : USB-PD receive framer: ordered-set hunt, 4b5b decode, EOP, CRC32.
// Revision : 1.0 - initial release
// ============================================================================
module usbpd_rx_decoder #(
    parameter int MAX_BYTE = 34
) (
    input  logic       clk,
    input  logic       srstz,
    input  logic       bit_vld,
    input  logic       bit_dat,
    input  logic       line_idle,
    output logic       sop_vld,
    output logic [2:0] sop_typ,
    output logic       byte_vld,
    output logic [7:0] byte_dat,
    output logic       pkt_end,
    output logic       crc_ok,
    output logic [5:0] byte_cnt,
    output logic       err_vld,
    output logic [1:0] err_cod
);
    localparam logic [4:0]  C_SY1 = 5'h18;
    localparam logic [4:0]  C_SY2 = 5'h11;
    localparam logic [4:0]  C_SY3 = 5'h06;
    localparam logic [4:0]  C_RS1 = 5'h07;
    localparam logic [4:0]  C_RS2 = 5'h19;
    localparam logic [4:0]  C_EOP = 5'h0D;
    // First symbol on the wire sits in the low five bits of each pattern.
    localparam logic [19:0] C_PAT_SOP  = {C_SY2, C_SY1, C_SY1, C_SY1};
    localparam logic [19:0] C_PAT_SOP1 = {C_SY3, C_SY3, C_SY1, C_SY1};
    localparam logic [19:0] C_PAT_SOP2 = {C_SY3, C_SY1, C_SY3, C_SY1};
    localparam logic [19:0] C_PAT_HRST = {C_RS2, C_RS1, C_RS1, C_RS1};
    localparam logic [19:0] C_PAT_CRST = {C_SY3, C_RS1, C_SY1, C_RS1};
    localparam logic [31:0] C_CRC_POLY = 32'hEDB88320;
    // Residual of the reflected register; bit-reversed it reads C704DD7B.
    localparam logic [31:0] C_CRC_RES  = 32'hDEBB20E3;
    localparam logic [5:0]  C_MAX_BYTE = 6'(MAX_BYTE);
    localparam logic [5:0]  C_MIN_BYTE = 6'd6;

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_DATA = 1'b1
    } state_t;

    function automatic logic [2:0] f_score(input logic [19:0] win, input logic [19:0] pat);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++)
            if (win[5*k +: 5] == pat[5*k +: 5]) n = n + 3'd1;
        return n;
    endfunction

    // Returns {valid, nibble}.
    function automatic logic [4:0] f_dec(input logic [4:0] sym);
        logic [4:0] r;
        case (sym)
            5'h1E: r = 5'h10;  5'h09: r = 5'h11;  5'h14: r = 5'h12;  5'h15: r = 5'h13;
            5'h0A: r = 5'h14;  5'h0B: r = 5'h15;  5'h0E: r = 5'h16;  5'h0F: r = 5'h17;
            5'h12: r = 5'h18;  5'h13: r = 5'h19;  5'h16: r = 5'h1A;  5'h17: r = 5'h1B;
            5'h1A: r = 5'h1C;  5'h1B: r = 5'h1D;  5'h1C: r = 5'h1E;  5'h1D: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] f_crc4(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int k = 0; k < 4; k++)
            c = (c >> 1) ^ (((c[0] ^ nib[k]) == 1'b1) ? C_CRC_POLY : 32'h0);
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [19:0] sr_q, sr_d;
    logic [2:0]  ph_q, ph_d;
    logic [31:0] crc_q, crc_d;
    logic        odd_q, odd_d;
    logic [3:0]  lo_q, lo_d;
    logic [5:0]  cnt_q, cnt_d;
    logic        sop_vld_q, sop_vld_d;
    logic [2:0]  sop_typ_q, sop_typ_d;
    logic        byte_vld_q, byte_vld_d;
    logic [7:0]  byte_dat_q, byte_dat_d;
    logic        pkt_end_q, pkt_end_d;
    logic        crc_ok_q, crc_ok_d;
    logic [5:0]  byte_cnt_q, byte_cnt_d;
    logic        err_vld_q, err_vld_d;
    logic [1:0]  err_cod_q, err_cod_d;

    logic [19:0] w_win;
    logic [4:0]  w_sym;
    logic [4:0]  w_dec;
    logic        w_hit;
    logic [2:0]  w_typ;

    assign w_win = {bit_dat, sr_q[19:1]};
    assign w_sym = w_win[19:15];
    assign w_dec = f_dec(w_sym);

    // Earlier entries take priority when two patterns both reach 3 of 4.
    always_comb begin
        w_hit = 1'b1;
        w_typ = 3'd0;
        if (f_score(w_win, C_PAT_SOP) >= 3'd3)       w_typ = 3'd0;
        else if (f_score(w_win, C_PAT_SOP1) >= 3'd3) w_typ = 3'd1;
        else if (f_score(w_win, C_PAT_SOP2) >= 3'd3) w_typ = 3'd2;
        else if (f_score(w_win, C_PAT_HRST) >= 3'd3) w_typ = 3'd3;
        else if (f_score(w_win, C_PAT_CRST) >= 3'd3) w_typ = 3'd4;
        else                                         w_hit = 1'b0;
    end

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        ph_d       = ph_q;
        crc_d      = crc_q;
        odd_d      = odd_q;
        lo_d       = lo_q;
        cnt_d      = cnt_q;
        sop_vld_d  = 1'b0;
        sop_typ_d  = sop_typ_q;
        byte_vld_d = 1'b0;
        byte_dat_d = byte_dat_q;
        pkt_end_d  = 1'b0;
        crc_ok_d   = crc_ok_q;
        byte_cnt_d = byte_cnt_q;
        err_vld_d  = 1'b0;
        err_cod_d  = err_cod_q;

        if (bit_vld) sr_d = w_win;

        case (state_q)
            ST_HUNT: begin
                if (bit_vld && w_hit) begin
                    sop_vld_d = 1'b1;
                    sop_typ_d = w_typ;
                    if (w_typ <= 3'd2) begin
                        state_d = ST_DATA;
                        ph_d    = 3'd0;
                        crc_d   = 32'hFFFFFFFF;
                        odd_d   = 1'b0;
                        cnt_d   = 6'd0;
                    end
                end
            end
            ST_DATA: begin
                if (line_idle) begin
                    err_vld_d = 1'b1;
                    err_cod_d = 2'd2;
                    state_d   = ST_HUNT;
                end else if (bit_vld) begin
                    if (ph_q != 3'd4) begin
                        ph_d = ph_q + 3'd1;
                    end else begin
                        ph_d = 3'd0;
                        if (w_dec[4]) begin
                            crc_d = f_crc4(crc_q, w_dec[3:0]);
                            if (!odd_q) begin
                                lo_d  = w_dec[3:0];
                                odd_d = 1'b1;
                            end else if (cnt_q >= C_MAX_BYTE) begin
                                err_vld_d = 1'b1;
                                err_cod_d = 2'd3;
                                state_d   = ST_HUNT;
                            end else begin
                                byte_vld_d = 1'b1;
                                byte_dat_d = {w_dec[3:0], lo_q};
                                cnt_d      = cnt_q + 6'd1;
                                odd_d      = 1'b0;
                            end
                        end else if (w_sym == C_EOP) begin
                            pkt_end_d  = 1'b1;
                            crc_ok_d   = !odd_q && (cnt_q >= C_MIN_BYTE) && (crc_q == C_CRC_RES);
                            byte_cnt_d = cnt_q;
                            state_d    = ST_HUNT;
                        end else begin
                            err_vld_d = 1'b1;
                            err_cod_d = 2'd1;
                            state_d   = ST_HUNT;
                        end
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srstz) begin
            state_q    <= ST_HUNT;
            sr_q       <= '0;
            ph_q       <= '0;
            crc_q      <= '0;
            odd_q      <= 1'b0;
            lo_q       <= '0;
            cnt_q      <= '0;
            sop_vld_q  <= 1'b0;
            sop_typ_q  <= '0;
            byte_vld_q <= 1'b0;
            byte_dat_q <= '0;
            pkt_end_q  <= 1'b0;
            crc_ok_q   <= 1'b0;
            byte_cnt_q <= '0;
            err_vld_q  <= 1'b0;
            err_cod_q  <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            ph_q       <= ph_d;
            crc_q      <= crc_d;
            odd_q      <= odd_d;
            lo_q       <= lo_d;
            cnt_q      <= cnt_d;
            sop_vld_q  <= sop_vld_d;
            sop_typ_q  <= sop_typ_d;
            byte_vld_q <= byte_vld_d;
            byte_dat_q <= byte_dat_d;
            pkt_end_q  <= pkt_end_d;
            crc_ok_q   <= crc_ok_d;
            byte_cnt_q <= byte_cnt_d;
            err_vld_q  <= err_vld_d;
            err_cod_q  <= err_cod_d;
        end
    end

    assign sop_vld  = sop_vld_q;
    assign sop_typ  = sop_typ_q;
    assign byte_vld = byte_vld_q;
    assign byte_dat = byte_dat_q;
    assign pkt_end  = pkt_end_q;
    assign crc_ok   = crc_ok_q;
    assign byte_cnt = byte_cnt_q;
    assign err_vld  = err_vld_q;
    assign err_cod  = err_cod_q;

endmodule
`default_nettype wire
